bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter SETTLE, default 1, number of SETUP cycles that read_en is held before the write strobe (legal range 1-15).
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  per-requester transfer request; bit i belongs to requester i.
REQ-005 src0, src1, src2  input  3 each  bus source code for requester i.
REQ-006 dst0, dst1, dst2  input  3 each  destination register index for requester i.
REQ-007 read_en  output  3  source select driven to the bus mux.
REQ-008 write_en  output  8  one-hot destination register load strobe.
REQ-009 gnt  output  3  one-hot grant; identifies the requester owning the bus.
REQ-010 done  output  3  one-hot, single-cycle completion pulse to the granted requester.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETUP and WRITE.
REQ-013 IDLE: read_en=3'd3 (bus drives 0), write_en=0, gnt=0, done=0, busy=0.
REQ-014 IDLE with req!=0 at a rising edge SHALL select one requester by round-robin, latch its src/dst, set gnt, and enter SETUP.
REQ-015 Round-robin: search order starts at (last_granted+1) mod 3 and wraps; last_granted updates on each grant.
REQ-016 SETUP: read_en=latched src, gnt held, write_en=0; a 4-bit counter SHALL hold SETUP for exactly SETTLE cycles, then enter WRITE.
REQ-017 WRITE, one cycle: read_en=latched src, write_en=1<<latched dst, done[granted]=1, gnt held; next state IDLE.
REQ-018 Latency: the req edge sampled in IDLE is followed by SETTLE SETUP cycles, then 1 WRITE cycle; total SETTLE+1 cycles busy per transfer.
REQ-019 The FSM SHALL return to IDLE for at least one cycle between transfers; back-to-back grants are spaced SETTLE+2 cycles.
REQ-020 src/dst changes after grant SHALL be ignored until the next grant.
REQ-021 Deassertion of req during SETUP/WRITE SHALL NOT abort the transfer; done is still pulsed.
REQ-022 src code 3 SHALL be a legal transfer (loads zero into dst); src codes 0-2 and 4-7 SHALL be passed through unmodified.
REQ-023 A requester holding req after done SHALL be treated as a new request and arbitrated against the other requesters.
REQ-024 Single active requester SHALL be granted on every arbitration, regardless of the round-robin pointer.
REQ-025 write_en and done SHALL never be asserted outside WRITE; at most one bit of each is high.

Reset
REQ-026 reset asserted SHALL immediately (no clock) force IDLE outputs per REQ-013, clear the counter, and set last_granted=2 so requester 0 wins the first arbitration.
REQ-027 reset during SETUP or WRITE SHALL abort the transfer with no write_en or done pulse after reset asserts.
REQ-028 The first arbitration SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-029 SETTLE=1, req=3'b001, src0=2, dst0=5 -> gnt=001 next cycle, read_en=2 for 2 cycles, write_en=8'h20 and done=001 in the 2nd cycle, busy high 2 cycles.
REQ-030 Fresh reset, req=3'b111 held -> grant order 0,1,2,0; each done pulse spaced 3 cycles (SETTLE=1).
REQ-031 SETTLE=3, req=3'b010, src1=7, dst1=0 -> read_en=7 for 4 cycles, write_en=8'h01 only in the 4th.
REQ-032 Grant to requester 2, then change src2/dst2 during SETUP -> write uses originally latched values.
REQ-033 Assert reset in SETUP cycle -> read_en=3, write_en=0, gnt=0 asynchronously; no done pulse; next req=3'b100 still yields grant to requester 2 (only requester).
REQ-034 req0 dropped during SETUP -> done[0] still pulses in WRITE; FSM returns to IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one of three requesters, holds the source on the
// bus for SETTLE setup cycles, then strobes the one-hot destination load.
module bus_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] src0,
    input  logic [2:0] src1,
    input  logic [2:0] src2,
    input  logic [2:0] dst0,
    input  logic [2:0] dst1,
    input  logic [2:0] dst2,
    output logic [2:0] read_en,
    output logic [7:0] write_en,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic       busy
);

    localparam int unsigned N_REQ = 3;
    localparam int unsigned SRC_W = 3;
    localparam int unsigned DST_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WE_W  = 8;
    localparam int unsigned IDX_W = 2;
    localparam logic [SRC_W-1:0] SRC_IDLE = SRC_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [DST_W-1:0]   dst_q, dst_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SRC_W-1:0]   read_en_q, read_en_d;
    logic [WE_W-1:0]    write_en_q, write_en_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [3:0]         req_ext;
    logic [SRC_W-1:0]   win_src;
    logic [DST_W-1:0]   win_dst;

    assign read_en  = read_en_q;
    assign write_en = write_en_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;

    // Round-robin search starting one past the last winner, wrapping mod 3
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        req_ext = {1'b0, req};
        cand    = last_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = (cand == IDX_W'(2)) ? IDX_W'(0) : cand + IDX_W'(1);
            if (!win_vld && req_ext[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        case (win_idx)
            IDX_W'(1): begin win_src = src1; win_dst = dst1; end
            IDX_W'(2): begin win_src = src2; win_dst = dst2; end
            default:   begin win_src = src0; win_dst = dst0; end
        endcase
    end

    // Next-state logic; output registers are loaded from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        src_d   = src_q;
        dst_d   = dst_q;
        gnt_d   = gnt_q;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_vld) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(1);
                    last_d  = win_idx;
                    src_d   = win_src;
                    dst_d   = win_dst;
                    gnt_d   = N_REQ'(1) << win_idx;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETTLE)) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
        endcase

        read_en_d  = (state_d == IDLE) ? SRC_IDLE : src_d;
        write_en_d = (state_d == WRITE) ? (WE_W'(1) << dst_d) : '0;
        done_d     = (state_d == WRITE) ? gnt_d : '0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= IDX_W'(2);
            src_q      <= '0;
            dst_q      <= '0;
            gnt_q      <= '0;
            read_en_q  <= SRC_IDLE;
            write_en_q <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            gnt_q      <= gnt_d;
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter, run on SETTLE=1 and SETTLE=3 instances
// sharing one stimulus stream against a transfer-level reference model.
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] src0, src1, src2, dst0, dst1, dst2;

    logic [2:0] re_a, g_a, d_a, re_b, g_b, d_b;
    logic [7:0] we_a, we_b;
    logic       b_a, b_b;

    bus_arbiter #(.SETTLE(1)) dut_a (
        .clock(clock), .reset(reset), .req(req),
        .src0(src0), .src1(src1), .src2(src2),
        .dst0(dst0), .dst1(dst1), .dst2(dst2),
        .read_en(re_a), .write_en(we_a), .gnt(g_a), .done(d_a), .busy(b_a)
    );

    bus_arbiter #(.SETTLE(3)) dut_b (
        .clock(clock), .reset(reset), .req(req),
        .src0(src0), .src1(src1), .src2(src2),
        .dst0(dst0), .dst1(dst1), .dst2(dst2),
        .read_en(re_b), .write_en(we_b), .gnt(g_b), .done(d_b), .busy(b_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        int who;
        int src;
        int dst;
        int due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   mcyc[2];
    int   mlast[2];
    int   mwho[2];
    int   msrc[2];

    function automatic int settle(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int src_of(input int i);
        return (i == 0) ? int'(src0) : (i == 1) ? int'(src1) : int'(src2);
    endfunction

    function automatic int dst_of(input int i);
        return (i == 0) ? int'(dst0) : (i == 1) ? int'(dst1) : int'(dst2);
    endfunction

    function automatic int sb_size(input int k);
        return (k == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic void sb_push(input int k, input exp_t e);
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endfunction

    function automatic exp_t sb_pop(input int k);
        if (k == 0) return q_a.pop_front();
        return q_b.pop_front();
    endfunction

    function automatic exp_t sb_head(input int k);
        if (k == 0) return q_a[0];
        return q_b[0];
    endfunction

    function automatic void model_flush();
        for (int k = 0; k < 2; k++) begin
            mcyc[k]  = 0;
            mlast[k] = 2;
            mwho[k]  = 0;
            msrc[k]  = 0;
        end
        q_a.delete();
        q_b.delete();
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, got, exp);
        end
    endtask

    // Reference model: transfer phase counter per instance (0 = idle, 1..SETTLE setup, SETTLE+1 write)
    always @(posedge clock) begin
        int   c;
        bit   found;
        exp_t e;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mcyc[k]  = 0;
                mlast[k] = 2;
            end else if (mcyc[k] != 0) begin
                if (mcyc[k] == settle(k) + 1) mcyc[k] = 0;
                else                          mcyc[k]++;
            end else if (req != 3'b000) begin
                found = 1'b0;
                for (int s = 1; s <= 3; s++) begin
                    c = (mlast[k] + s) % 3;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        e.who = c;
                        e.src = src_of(c);
                        e.dst = dst_of(c);
                        e.due = cyc + settle(k);
                        sb_push(k, e);
                        mwho[k]  = c;
                        msrc[k]  = e.src;
                        mlast[k] = c;
                        mcyc[k]  = 1;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle bus state, and completion pulses popped from the scoreboard
    always @(posedge clock) begin
        logic [2:0] re, g, d;
        logic [7:0] we;
        logic       b;
        exp_t       e;
        #1;
        for (int k = 0; k < 2; k++) begin
            re = (k == 0) ? re_a : re_b;
            g  = (k == 0) ? g_a  : g_b;
            d  = (k == 0) ? d_a  : d_b;
            we = (k == 0) ? we_a : we_b;
            b  = (k == 0) ? b_a  : b_b;
            chk("busy", k, 32'(b), 32'(mcyc[k] != 0));
            chk("gnt", k, 32'(g), (mcyc[k] != 0) ? (32'd1 << mwho[k]) : 32'd0);
            chk("read_en", k, 32'(re), (mcyc[k] != 0) ? 32'(msrc[k]) : 32'd3);
            if (d != 3'b000) begin
                if (sb_size(k) == 0) begin
                    chk("done_unexpected", k, 32'(d), 32'd0);
                end else begin
                    e = sb_pop(k);
                    chk("done", k, 32'(d), 32'd1 << e.who);
                    chk("write_en", k, 32'(we), 32'd1 << e.dst);
                    chk("done_time", k, 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("write_en_idle", k, 32'(we), 32'd0);
                if (sb_size(k) != 0) begin
                    e = sb_head(k);
                    if (e.due <= cyc) chk("done_missing", k, 32'(d), 32'd1 << e.who);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] r);
        req  = r;
        src0 = 3'($urandom_range(0, 7));
        src1 = 3'($urandom_range(0, 7));
        src2 = 3'($urandom_range(0, 7));
        dst0 = 3'($urandom_range(0, 7));
        dst1 = 3'($urandom_range(0, 7));
        dst2 = 3'($urandom_range(0, 7));
    endtask

    // Asynchronous reset pulse from mid-cycle; outputs must go idle with no clock edge
    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b1;
        model_flush();
        #1;
        chk("rst_read_en_a", 0, 32'(re_a), 32'd3);
        chk("rst_write_en_a", 0, 32'(we_a), 32'd0);
        chk("rst_gnt_a", 0, 32'(g_a), 32'd0);
        chk("rst_done_a", 0, 32'(d_a), 32'd0);
        chk("rst_busy_a", 0, 32'(b_a), 32'd0);
        chk("rst_read_en_b", 1, 32'(re_b), 32'd3);
        chk("rst_write_en_b", 1, 32'(we_b), 32'd0);
        chk("rst_gnt_b", 1, 32'(g_b), 32'd0);
        chk("rst_done_b", 1, 32'(d_b), 32'd0);
        chk("rst_busy_b", 1, 32'(b_b), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        src0  = '0; src1 = '0; src2 = '0;
        dst0  = '0; dst1 = '0; dst2 = '0;
        model_flush();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // All requesters held: grant order must rotate 0,1,2,0,...
        repeat (40) begin
            drive(3'b111);
            @(negedge clock);
        end

        // Random requests with src/dst churn and occasional resets
        repeat (3000) begin
            if ($urandom_range(0, 99) < 2) begin
                reset_pulse();
            end else begin
                drive(3'($urandom_range(0, 7)));
                @(negedge clock);
            end
        end

        // Reset while in setup, then a lone requester 2
        reset_pulse();
        drive(3'b001);
        @(negedge clock);
        req = 3'b000;
        reset = 1'b1;
        model_flush();
        #1;
        chk("setup_rst_gnt_b", 1, 32'(g_b), 32'd0);
        chk("setup_rst_write_en_b", 1, 32'(we_b), 32'd0);
        chk("setup_rst_read_en_b", 1, 32'(re_b), 32'd3);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) begin
            drive(3'b100);
            @(negedge clock);
        end

        req = 3'b000;
        repeat (10) @(negedge clock);
        chk("drain", 0, 32'(sb_size(0)), 32'd0);
        chk("drain", 1, 32'(sb_size(1)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
